// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the memory stage
package cpu_pkg;
  localparam int TAG_W = 8;
  localparam logic BUS_RW_READ = 1'b0;
  localparam logic BUS_RW_WRITE = 1'b1;
  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} state_e;
endpackage

// File: rtl/cpu_memory_access_if.sv
// cpu_memory_access_if: execute bundle in, data bus, writeback bundle out
interface cpu_memory_access_if;
  import cpu_pkg::*;
  logic [TAG_W-1:0] i_tag;
  logic [4:0] i_inst_rd;
  logic [31:0] i_rd;
  logic i_branch;
  logic [31:0] i_pc_next;
  logic i_mem_read;
  logic i_mem_write;
  logic [31:0] i_mem_address;
  logic o_busy;
  logic o_bus_request;
  logic o_bus_rw;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic [TAG_W-1:0] o_tag;
  logic [4:0] o_inst_rd;
  logic [31:0] o_rd;
  logic o_branch;
  logic [31:0] o_pc_next;
  logic o_fault;
  logic [31:0] o_fault_address;
  modport slave (
    input i_tag, i_inst_rd, i_rd, i_branch, i_pc_next, i_mem_read, i_mem_write, i_mem_address,
    input i_bus_ready, i_bus_rdata,
    output o_busy, o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
    output o_tag, o_inst_rd, o_rd, o_branch, o_pc_next, o_fault, o_fault_address
  );
  modport master (
    output i_tag, i_inst_rd, i_rd, i_branch, i_pc_next, i_mem_read, i_mem_write, i_mem_address,
    output i_bus_ready, i_bus_rdata,
    input o_busy, o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
    input o_tag, o_inst_rd, o_rd, o_branch, o_pc_next, o_fault, o_fault_address
  );
endinterface

// File: rtl/cpu_bus_timeout.sv
// cpu_bus_timeout: wait-cycle counter; expired on the cycle the next count would hit the limit
module cpu_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = i_clear ? '0 : i_enable ? cnt_q + 16'd1 : cnt_q;
  assign o_expired = i_enable && cnt_q == LAST;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/cpu_memory_access.sv
// cpu_memory_access: memory stage doing word loads/stores and forwarding a tagged bundle
module cpu_memory_access
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic i_clock,
  input logic i_reset,
  cpu_memory_access_if.slave io
);
  state_e state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d, lat_tag_q, lat_tag_d;
  logic [4:0] inst_rd_q, inst_rd_d, lat_rd_q, lat_rd_d;
  logic [31:0] rd_q, rd_d, pc_q, pc_d, lat_pc_q, lat_pc_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, fault_addr_q, fault_addr_d;
  logic branch_q, branch_d, lat_br_q, lat_br_d, req_q, req_d, rw_q, rw_d, fault_q, fault_d;
  logic waiting, expired, mem_op, bad;
  assign waiting = state_q != IDLE;
  assign mem_op = io.i_mem_read | io.i_mem_write;
  assign bad = (io.i_mem_read & io.i_mem_write) | (io.i_mem_address[1:0] != 2'b00);
  cpu_bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_clear(!waiting),
    .i_enable(waiting),
    .o_expired(expired)
  );
  always_comb begin
    state_d = state_q;
    tag_d = tag_q;
    inst_rd_d = inst_rd_q;
    rd_d = rd_q;
    branch_d = branch_q;
    pc_d = pc_q;
    lat_tag_d = lat_tag_q;
    lat_rd_d = lat_rd_q;
    lat_br_d = lat_br_q;
    lat_pc_d = lat_pc_q;
    req_d = req_q;
    rw_d = rw_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    fault_d = fault_q;
    fault_addr_d = fault_addr_q;
    if (state_q == IDLE) begin
      if (io.i_tag != tag_q) begin
        if (!mem_op || bad) begin
          tag_d = io.i_tag;
          inst_rd_d = mem_op ? 5'd0 : io.i_inst_rd;
          rd_d = io.i_rd;
          branch_d = io.i_branch;
          pc_d = io.i_pc_next;
          fault_d = fault_q | mem_op;
          fault_addr_d = (mem_op && !fault_q) ? io.i_mem_address : fault_addr_q;
        end else begin
          lat_tag_d = io.i_tag;
          lat_rd_d = io.i_inst_rd;
          lat_br_d = io.i_branch;
          lat_pc_d = io.i_pc_next;
          req_d = 1'b1;
          rw_d = io.i_mem_write ? BUS_RW_WRITE : BUS_RW_READ;
          addr_d = {io.i_mem_address[31:2], 2'b00};
          wdata_d = io.i_mem_write ? io.i_rd : wdata_q;
          state_d = io.i_mem_write ? WRITE_WAIT : READ_WAIT;
        end
      end
    end else if (io.i_bus_ready || expired) begin
      // ready wins over a simultaneous expiry
      state_d = IDLE;
      req_d = 1'b0;
      tag_d = lat_tag_q;
      branch_d = lat_br_q;
      pc_d = lat_pc_q;
      inst_rd_d = (io.i_bus_ready && state_q == READ_WAIT) ? lat_rd_q : 5'd0;
      rd_d = !io.i_bus_ready ? 32'd0 : state_q == READ_WAIT ? io.i_bus_rdata : rd_q;
      fault_d = fault_q | !io.i_bus_ready;
      fault_addr_d = (!io.i_bus_ready && !fault_q) ? addr_q : fault_addr_q;
    end
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      tag_q <= '0;
      inst_rd_q <= '0;
      rd_q <= '0;
      branch_q <= 1'b0;
      pc_q <= '0;
      lat_tag_q <= '0;
      lat_rd_q <= '0;
      lat_br_q <= 1'b0;
      lat_pc_q <= '0;
      req_q <= 1'b0;
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      inst_rd_q <= inst_rd_d;
      rd_q <= rd_d;
      branch_q <= branch_d;
      pc_q <= pc_d;
      lat_tag_q <= lat_tag_d;
      lat_rd_q <= lat_rd_d;
      lat_br_q <= lat_br_d;
      lat_pc_q <= lat_pc_d;
      req_q <= req_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end
  assign io.o_busy = waiting;
  assign io.o_bus_request = req_q;
  assign io.o_bus_rw = rw_q;
  assign io.o_bus_address = addr_q;
  assign io.o_bus_wdata = wdata_q;
  assign io.o_tag = tag_q;
  assign io.o_inst_rd = inst_rd_q;
  assign io.o_rd = rd_q;
  assign io.o_branch = branch_q;
  assign io.o_pc_next = pc_q;
  assign io.o_fault = fault_q;
  assign io.o_fault_address = fault_addr_q;
endmodule

// File: tb/tb_cpu_memory_access.sv
// tb_cpu_memory_access: directed vectors and multi-cycle sequences for the memory stage
module tb_cpu_memory_access;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;
  cpu_memory_access_if bus ();
  cpu_memory_access #(.TIMEOUT_CYCLES(4)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .io(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] tag;
    logic [4:0] rd_idx;
    logic [31:0] val;
    logic br;
    logic [31:0] pc;
    logic [7:0] e_tag;
    logic [4:0] e_rd_idx;
    logic [31:0] e_val;
    logic e_br;
    logic [31:0] e_pc;
  } vec_t;
  vec_t v [4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [7:0] tag, input logic [4:0] rdi, input logic [31:0] val,
                       input logic rd, input logic wr, input logic [31:0] addr,
                       input logic br, input logic [31:0] pc);
    bus.i_tag = tag;
    bus.i_inst_rd = rdi;
    bus.i_rd = val;
    bus.i_mem_read = rd;
    bus.i_mem_write = wr;
    bus.i_mem_address = addr;
    bus.i_branch = br;
    bus.i_pc_next = pc;
  endtask
  initial begin
    v[0] = '{8'h01, 5'd5, 32'h0000_1234, 1'b0, 32'h4, 8'h01, 5'd5, 32'h0000_1234, 1'b0, 32'h4};
    v[1] = '{8'h02, 5'd7, 32'hAAAA_5555, 1'b1, 32'h80, 8'h02, 5'd7, 32'hAAAA_5555, 1'b1, 32'h80};
    v[2] = '{8'h02, 5'd9, 32'h0, 1'b0, 32'h99, 8'h02, 5'd7, 32'hAAAA_5555, 1'b1, 32'h80};
    v[3] = '{8'h03, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h1000, 8'h03, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h1000};
    drive(8'h00, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    bus.i_bus_ready = 1'b0;
    bus.i_bus_rdata = 32'd0;
    step();
    step();
    chk("reset_tag", bus.o_tag, 32'h0);
    chk("reset_busy", bus.o_busy, 32'h0);
    chk("reset_req", bus.o_bus_request, 32'h0);
    chk("reset_fault", bus.o_fault, 32'h0);
    chk("reset_rd", bus.o_rd, 32'h0);
    #4 rst_n = 1'b1;
    step();
    // pass-through vectors, one per cycle back-to-back
    for (int i = 0; i < 4; i++) begin
      drive(v[i].tag, v[i].rd_idx, v[i].val, 1'b0, 1'b0, 32'd0, v[i].br, v[i].pc);
      step();
      chk($sformatf("pt%0d_tag", i), bus.o_tag, v[i].e_tag);
      chk($sformatf("pt%0d_inst_rd", i), bus.o_inst_rd, v[i].e_rd_idx);
      chk($sformatf("pt%0d_rd", i), bus.o_rd, v[i].e_val);
      chk($sformatf("pt%0d_branch", i), bus.o_branch, v[i].e_br);
      chk($sformatf("pt%0d_pc", i), bus.o_pc_next, v[i].e_pc);
      chk($sformatf("pt%0d_busy", i), bus.o_busy, 32'h0);
    end
    // load, ready sampled on the fourth edge after accept
    drive(8'h04, 5'd3, 32'h5555, 1'b1, 1'b0, 32'h100, 1'b1, 32'h200);
    step();
    chk("ld_req", bus.o_bus_request, 32'h1);
    chk("ld_rw", bus.o_bus_rw, 32'h0);
    chk("ld_addr", bus.o_bus_address, 32'h100);
    chk("ld_busy0", bus.o_busy, 32'h1);
    chk("ld_tag_hold", bus.o_tag, 32'h03);
    bus.i_pc_next = 32'hBAD;
    bus.i_branch = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("ld_busy%0d", i), bus.o_busy, 32'h1);
      chk($sformatf("ld_req%0d", i), bus.o_bus_request, 32'h1);
    end
    bus.i_bus_ready = 1'b1;
    bus.i_bus_rdata = 32'hDEAD_BEEF;
    step();
    bus.i_bus_ready = 1'b0;
    chk("ld_tag", bus.o_tag, 32'h04);
    chk("ld_rd", bus.o_rd, 32'hDEAD_BEEF);
    chk("ld_inst_rd", bus.o_inst_rd, 32'd3);
    chk("ld_branch_latched", bus.o_branch, 32'h1);
    chk("ld_pc_latched", bus.o_pc_next, 32'h200);
    chk("ld_req_drop", bus.o_bus_request, 32'h0);
    chk("ld_busy_end", bus.o_busy, 32'h0);
    // store with ready already high
    drive(8'h05, 5'd6, 32'hCAFE, 1'b0, 1'b1, 32'h204, 1'b0, 32'h300);
    bus.i_bus_ready = 1'b1;
    step();
    chk("st_req", bus.o_bus_request, 32'h1);
    chk("st_rw", bus.o_bus_rw, 32'h1);
    chk("st_addr", bus.o_bus_address, 32'h204);
    chk("st_wdata", bus.o_bus_wdata, 32'hCAFE);
    chk("st_tag_hold", bus.o_tag, 32'h04);
    step();
    bus.i_bus_ready = 1'b0;
    chk("st_tag", bus.o_tag, 32'h05);
    chk("st_inst_rd", bus.o_inst_rd, 32'h0);
    chk("st_req_drop", bus.o_bus_request, 32'h0);
    chk("st_busy", bus.o_busy, 32'h0);
    // misaligned store
    drive(8'h06, 5'd8, 32'h11, 1'b0, 1'b1, 32'h203, 1'b0, 32'h304);
    step();
    chk("mis_req", bus.o_bus_request, 32'h0);
    chk("mis_busy", bus.o_busy, 32'h0);
    chk("mis_fault", bus.o_fault, 32'h1);
    chk("mis_faddr", bus.o_fault_address, 32'h203);
    chk("mis_tag", bus.o_tag, 32'h06);
    chk("mis_inst_rd", bus.o_inst_rd, 32'h0);
    // load that never sees ready
    drive(8'h07, 5'd4, 32'h99, 1'b1, 1'b0, 32'h400, 1'b0, 32'h308);
    step();
    chk("to_req0", bus.o_bus_request, 32'h1);
    step();
    step();
    step();
    chk("to_req3", bus.o_bus_request, 32'h1);
    chk("to_tag_hold", bus.o_tag, 32'h06);
    step();
    chk("to_req_drop", bus.o_bus_request, 32'h0);
    chk("to_busy", bus.o_busy, 32'h0);
    chk("to_tag", bus.o_tag, 32'h07);
    chk("to_rd", bus.o_rd, 32'h0);
    chk("to_inst_rd", bus.o_inst_rd, 32'h0);
    chk("to_fault", bus.o_fault, 32'h1);
    chk("to_faddr_first", bus.o_fault_address, 32'h203);
    // asynchronous reset in the middle of a read
    drive(8'h08, 5'd2, 32'h0, 1'b1, 1'b0, 32'h500, 1'b0, 32'h30C);
    step();
    chk("rst_pre_req", bus.o_bus_request, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", bus.o_bus_request, 32'h0);
    chk("rst_async_tag", bus.o_tag, 32'h0);
    chk("rst_async_busy", bus.o_busy, 32'h0);
    chk("rst_async_fault", bus.o_fault, 32'h0);
    drive(8'h00, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1 rst_n = 1'b1;
    step();
    drive(8'hFF, 5'd2, 32'h42, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10);
    step();
    chk("wrap_ff_tag", bus.o_tag, 32'hFF);
    chk("wrap_ff_rd", bus.o_rd, 32'h42);
    drive(8'h00, 5'd1, 32'h43, 1'b0, 1'b0, 32'd0, 1'b0, 32'h14);
    step();
    chk("wrap_00_tag", bus.o_tag, 32'h00);
    chk("wrap_00_rd", bus.o_rd, 32'h43);
    chk("wrap_00_inst_rd", bus.o_inst_rd, 32'd1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
